// File: rtl/robo_ctrl_if.sv
// Sensor/command bundle between the navigation controller (master) and the
// maze map/robot memory block (slave).
interface robo_ctrl_if #(
    parameter int COUNT_W = 16
);
    logic               enable;
    logic               head_in;
    logic               left_in;
    logic               under_in;
    logic               barrier_in;
    logic               avancar;
    logic               girar;
    logic               remover;
    logic               done;
    logic               stuck;
    logic [COUNT_W-1:0] move_count;

    modport master (
        input  enable, head_in, left_in, under_in, barrier_in,
        output avancar, girar, remover, done, stuck, move_count
    );

    modport slave (
        output enable, head_in, left_in, under_in, barrier_in,
        input  avancar, girar, remover, done, stuck, move_count
    );
endinterface

// File: rtl/robo_ctrl.sv
// Left-hand wall-follower navigation controller for the maze robot.
// Optional step-limit watchdog enabled by defining STEP_LIMIT_EN.
module robo_ctrl #(
    parameter int                 COUNT_W   = 16,
    parameter logic [COUNT_W-1:0] MAX_STEPS = 16'd1000
) (
    input  logic        clock,
    input  logic        reset,
    robo_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECIDE    = 3'd1,
        ST_ROT_LEFT  = 3'd2,
        ST_ADVANCE   = 3'd3,
        ST_REMOVE    = 3'd4,
        ST_ROT_RIGHT = 3'd5,
        ST_DONE      = 3'd6
`ifdef STEP_LIMIT_EN
        , ST_FAIL    = 3'd7
`endif
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic               turned_left_r;
    logic [1:0]         rr_cnt_r;
    logic [COUNT_W-1:0] move_count_r;
    logic               step_limit_s;
    logic               avancar_nxt_s;
    logic               girar_nxt_s;
    logic               done_nxt_s;
    logic               stuck_nxt_s;
    logic               avancar_r;
    logic               girar_r;
    logic               done_r;
    logic               stuck_r;

`ifdef STEP_LIMIT_EN
    assign step_limit_s = (move_count_r >= MAX_STEPS);
`else
    assign step_limit_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; DECIDE rows are tested in priority order
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable) state_nxt_s = ST_DECIDE;
                else            state_nxt_s = ST_IDLE;
            end
            ST_DECIDE: begin
                if (!bus.enable)                          state_nxt_s = ST_IDLE;
                else if (step_limit_s) begin
`ifdef STEP_LIMIT_EN
                    state_nxt_s = ST_FAIL;
`else
                    state_nxt_s = ST_IDLE;
`endif
                end
                else if (bus.under_in)                    state_nxt_s = ST_DONE;
                else if (!bus.left_in && !turned_left_r)  state_nxt_s = ST_ROT_LEFT;
                else if (bus.barrier_in)                  state_nxt_s = ST_REMOVE;
                else if (!bus.head_in)                    state_nxt_s = ST_ADVANCE;
                else                                      state_nxt_s = ST_ROT_RIGHT;
            end
            ST_ROT_LEFT:  state_nxt_s = ST_DECIDE;
            ST_ADVANCE:   state_nxt_s = ST_DECIDE;
            ST_REMOVE: begin
                if (bus.barrier_in) state_nxt_s = ST_REMOVE;
                else                state_nxt_s = ST_DECIDE;
            end
            ST_ROT_RIGHT: begin
                if (rr_cnt_r == 2'd2) state_nxt_s = ST_DECIDE;
                else                  state_nxt_s = ST_ROT_RIGHT;
            end
            ST_DONE:      state_nxt_s = ST_DONE;
`ifdef STEP_LIMIT_EN
            ST_FAIL:      state_nxt_s = ST_FAIL;
`endif
            default:      state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the command flops line up with it
    always_comb begin
        avancar_nxt_s = 1'b0;
        girar_nxt_s   = 1'b0;
        done_nxt_s    = 1'b0;
        stuck_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_ADVANCE:   avancar_nxt_s = 1'b1;
            ST_ROT_LEFT:  girar_nxt_s   = 1'b1;
            ST_ROT_RIGHT: girar_nxt_s   = 1'b1;
            ST_DONE:      done_nxt_s    = 1'b1;
`ifdef STEP_LIMIT_EN
            ST_FAIL:      stuck_nxt_s   = 1'b1;
`endif
            default: begin
                avancar_nxt_s = 1'b0;
                girar_nxt_s   = 1'b0;
            end
        endcase
    end

    // Registered command and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            avancar_r <= 1'b0;
            girar_r   <= 1'b0;
            done_r    <= 1'b0;
            stuck_r   <= 1'b0;
        end else begin
            avancar_r <= avancar_nxt_s;
            girar_r   <= girar_nxt_s;
            done_r    <= done_nxt_s;
            stuck_r   <= stuck_nxt_s;
        end
    end

    // Left-turn memory, right-turn cycle counter and saturating move counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            turned_left_r <= 1'b0;
            rr_cnt_r      <= 2'd0;
            move_count_r  <= {COUNT_W{1'b0}};
        end else begin
            if (state_r == ST_ROT_LEFT)     turned_left_r <= 1'b1;
            else if (state_r == ST_ADVANCE) turned_left_r <= 1'b0;
            else                            turned_left_r <= turned_left_r;

            if ((state_r == ST_ROT_RIGHT) && (rr_cnt_r != 2'd2)) rr_cnt_r <= rr_cnt_r + 2'd1;
            else                                                 rr_cnt_r <= 2'd0;

            if ((state_r == ST_ADVANCE) && (move_count_r != CNT_MAX))
                move_count_r <= move_count_r + CNT_ONE;
            else
                move_count_r <= move_count_r;
        end
    end

    // remover tracks barrier_in directly so it drops the cycle the barrier clears
    assign bus.remover    = (state_r == ST_REMOVE) & bus.barrier_in;
    assign bus.avancar    = avancar_r;
    assign bus.girar      = girar_r;
    assign bus.done       = done_r;
    assign bus.stuck      = stuck_r;
    assign bus.move_count = move_count_r;

endmodule

// File: tb/tb_robo_ctrl.sv
// Scoreboard bench for robo_ctrl: expected command vectors are queued per
// cycle and compared against the DUT; includes a small map/robot memory model.
module tb_robo_ctrl;

    localparam int CW = 16;

    logic clock;
    logic reset;

    logic drv_enable, drv_head, drv_left, drv_under, drv_barrier;
    logic loop_mode;
    logic mdl_load;
    logic [1:0] mdl_lvl;
    logic [1:0] mdl_hit;
    logic mdl_moved;

    int checks;
    int errors;

    logic [2:0] sb_q[$];

    robo_ctrl_if #(.COUNT_W(CW)) bus_if ();

    robo_ctrl #(.COUNT_W(CW), .MAX_STEPS(16'd4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    assign bus_if.enable     = drv_enable;
    assign bus_if.head_in    = loop_mode ? 1'b0 : drv_head;
    assign bus_if.left_in    = loop_mode ? 1'b1 : drv_left;
    assign bus_if.under_in   = loop_mode ? mdl_moved : drv_under;
    assign bus_if.barrier_in = loop_mode ? (mdl_lvl != 2'd0) : drv_barrier;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: one barrier level lost per 3 hammer cycles; advancing reaches the target
    always @(posedge clock) begin
        if (mdl_load) begin
            mdl_lvl   <= 2'd3;
            mdl_hit   <= 2'd0;
            mdl_moved <= 1'b0;
        end else begin
            if (bus_if.remover) begin
                if (mdl_hit == 2'd2) begin
                    mdl_hit <= 2'd0;
                    mdl_lvl <= mdl_lvl - 2'd1;
                end else begin
                    mdl_hit <= mdl_hit + 2'd1;
                end
            end
            if (bus_if.avancar) mdl_moved <= 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_cmd(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v);
    endtask

    // Advance one clock and compare {avancar,girar,remover} against the queue head
    task automatic step(input string tag);
        logic [2:0] e;
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(tag, {29'd0, bus_if.avancar, bus_if.girar, bus_if.remover}, {29'd0, e});
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((sb_q.size() > 0) && (guard < 200)) begin
            step(tag);
            guard++;
        end
        check_val({tag, "_drained"}, sb_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        drv_enable = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_ADV  = 3'b100;
    localparam logic [2:0] C_GIR  = 3'b010;
    localparam logic [2:0] C_REM  = 3'b001;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        loop_mode = 1'b0;
        mdl_load = 1'b1;
        drv_enable = 1'b0;
        drv_head = 1'b0;
        drv_left = 1'b0;
        drv_under = 1'b0;
        drv_barrier = 1'b0;

        do_reset();
        check_val("rst_cmds", {29'd0, bus_if.avancar, bus_if.girar, bus_if.remover}, 32'd0);
        check_val("rst_done", {31'd0, bus_if.done}, 32'd0);
        check_val("rst_stuck", {31'd0, bus_if.stuck}, 32'd0);
        check_val("rst_count", {16'd0, bus_if.move_count}, 32'd0);

        // Dead end: three-cycle right turn, then reset mid way through the next one
        drv_left = 1'b1; drv_head = 1'b1; drv_barrier = 1'b0; drv_under = 1'b0;
        drv_enable = 1'b1;
        exp_cmd(C_NONE, 1); exp_cmd(C_GIR, 3); exp_cmd(C_NONE, 1); exp_cmd(C_GIR, 2);
        drain("rot_right");
        reset = 1'b0;
        #1;
        check_val("rst_async_girar", {31'd0, bus_if.girar}, 32'd0);
        drv_enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        check_val("rst_count_after", {16'd0, bus_if.move_count}, 32'd0);
        exp_cmd(C_NONE, 4);
        drain("idle_hold");

        // Open left: one left turn, then an advance instead of a second turn
        do_reset();
        drv_left = 1'b0; drv_head = 1'b0; drv_barrier = 1'b0; drv_under = 1'b0;
        drv_enable = 1'b1;
        exp_cmd(C_NONE, 1); exp_cmd(C_GIR, 1); exp_cmd(C_NONE, 1); exp_cmd(C_ADV, 1); exp_cmd(C_NONE, 1);
        drain("left_adv");
        drv_enable = 1'b0;
        check_val("left_adv_count", {16'd0, bus_if.move_count}, 32'd1);
        exp_cmd(C_NONE, 3);
        drain("disable");

        // Closed loop: BARRIER9 ahead, left blocked, target cell behind the barrier
        mdl_load = 1'b1;
        do_reset();
        mdl_load = 1'b0;
        loop_mode = 1'b1;
        drv_enable = 1'b1;
        exp_cmd(C_NONE, 1); exp_cmd(C_REM, 9); exp_cmd(C_NONE, 2); exp_cmd(C_ADV, 1); exp_cmd(C_NONE, 1);
        drain("barrier");
        check_val("barrier_done_early", {31'd0, bus_if.done}, 32'd0);
        check_val("barrier_count", {16'd0, bus_if.move_count}, 32'd1);
        exp_cmd(C_NONE, 1);
        drain("target");
        check_val("target_done", {31'd0, bus_if.done}, 32'd1);
        drv_enable = 1'b0;
        exp_cmd(C_NONE, 2);
        drain("done_en0");
        drv_enable = 1'b1;
        exp_cmd(C_NONE, 3);
        drain("done_en1");
        check_val("done_sticky", {31'd0, bus_if.done}, 32'd1);
        loop_mode = 1'b0;

        // Straight open corridor
        do_reset();
        drv_left = 1'b1; drv_head = 1'b0; drv_barrier = 1'b0; drv_under = 1'b0;
        drv_enable = 1'b1;
        exp_cmd(C_NONE, 1);
        for (int i = 0; i < 4; i++) begin
            exp_cmd(C_ADV, 1);
            exp_cmd(C_NONE, 1);
        end
        drain("corridor");
        check_val("corridor_count4", {16'd0, bus_if.move_count}, 32'd4);
`ifdef STEP_LIMIT_EN
        exp_cmd(C_NONE, 4);
        drain("fail_hold");
        check_val("fail_stuck", {31'd0, bus_if.stuck}, 32'd1);
        check_val("fail_count", {16'd0, bus_if.move_count}, 32'd4);
`else
        exp_cmd(C_ADV, 1); exp_cmd(C_NONE, 1);
        drain("corridor_more");
        check_val("corridor_count5", {16'd0, bus_if.move_count}, 32'd5);
        check_val("corridor_stuck", {31'd0, bus_if.stuck}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
